// File: rtl/ps2_rx.sv
// PS/2 receive front end: pin synchronizer, frame deserializer with parity,
// stop-bit and inter-edge timeout checks, and a show-ahead scancode FIFO.
module ps2_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_n;

    logic          clk_s1, clk_s2, clk_s3;
    logic          dat_s1, dat_s2;
    logic          fall;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          timeout;
    logic          push;
    logic          bad;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          empty, full, pop, wr;

    // Bus idles high, so the synchronizer resets to 1 to avoid a false fall.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            {clk_s3, clk_s2, clk_s1} <= 3'b111;
            {dat_s2, dat_s1}         <= 2'b11;
        end else begin
            {clk_s3, clk_s2, clk_s1} <= {clk_s2, clk_s1, ps2_clk};
            {dat_s2, dat_s1}         <= {dat_s1, ps2_data};
        end
    end

    assign fall    = clk_s3 & ~clk_s2;
    assign timeout = (state != IDLE) && !fall
                     && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        push    = 1'b0;
        bad     = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall && !dat_s2) state_n = DATA;
            end
            DATA: begin
                if (fall && bit_cnt == 3'd7) state_n = PARITY;
            end
            PARITY: begin
                if (fall) state_n = STOP;
            end
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    if (dat_s2 && (^shift ^ par_bit)) push = 1'b1;
                    else bad = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (timeout) state_n = IDLE;
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            shift     <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            tcnt      <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= bad | timeout;
            if (state == IDLE || fall || timeout) tcnt <= '0;
            else tcnt <= tcnt + TW'(1);
            if (state == IDLE) bit_cnt <= '0;
            if (fall && state == DATA) begin
                shift   <= {dat_s2, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (fall && state == PARITY) par_bit <= dat_s2;
        end
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW])
                   && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = rd_en & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign wr    = push & (~full | pop);

    always_ff @(posedge sys_clk) begin
        if (wr) mem[wptr[AW-1:0]] <= shift;
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) wptr <= wptr + (AW+1)'(1);
            if (pop) rptr <= rptr + (AW+1)'(1);
            if (push && full && !pop) overflow <= 1'b1;
            else if (pop) overflow <= 1'b0;
        end
    end

    assign ready   = ~empty;
    assign rd_data = empty ? 8'h00 : mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx with a byte scoreboard queue.
module tb_ps2_rx;

    localparam int DEPTH = 8;
    localparam int TO    = 200;
    localparam int HALF  = 20;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int e0;
    logic [7:0] q[$];
    logic exp_ovf = 1'b0;
    logic rdy_pre, rdy_post;

    ps2_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .ready(ready),
        .overflow(overflow),
        .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) if (frame_err) err_cnt++;

    initial begin
        #2ms;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge sys_clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pflip,
                              input bit stopb, input bit pop_at_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ pflip);
        ps2_data = stopb;
        repeat (HALF) @(negedge sys_clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge sys_clk);
        rdy_pre = ready;
        if (pop_at_stop) rd_en = 1'b1;
        @(negedge sys_clk);
        rd_en = 1'b0;
        rdy_post = ready;
        if (pop_at_stop && q.size() > 0) begin
            void'(q.pop_front());
            exp_ovf = 1'b0;
        end
        if (!pflip && stopb) begin
            if (q.size() < DEPTH) q.push_back(d);
            else exp_ovf = 1'b1;
        end
        repeat (HALF - 3) @(negedge sys_clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge sys_clk);
    endtask

    task automatic pop_chk();
        logic [7:0] e;
        e = (q.size() > 0) ? q.pop_front() : 8'hxx;
        chk("pop_ready", ready, 1);
        chk("pop_data", rd_data, e);
        rd_en = 1'b1;
        @(negedge sys_clk);
        rd_en = 1'b0;
        exp_ovf = 1'b0;
        chk("pop_ovf", overflow, exp_ovf);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("rst_ready", ready, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        rst = 1'b1;
        repeat (5) @(negedge sys_clk);

        send_frame(8'h1C, 0, 1, 0);
        chk("lat_early", rdy_pre, 0);
        chk("lat_push", rdy_post, 1);
        pop_chk();
        chk("empty_1c", ready, 0);

        e0 = err_cnt;
        send_frame(8'h1C, 1, 1, 0);
        chk("par_ready", ready, 0);
        chk("par_ferr", err_cnt - e0, 1);
        send_frame(8'hF0, 0, 1, 0);
        pop_chk();

        e0 = err_cnt;
        send_frame(8'hE0, 0, 0, 0);
        chk("stop_ready", ready, 0);
        chk("stop_ferr", err_cnt - e0, 1);

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1, 0);
        chk("ovf_set", overflow, exp_ovf);
        chk("ovf_ready", ready, 1);
        for (int i = 0; i < 8; i++) pop_chk();
        chk("ovf_drain", ready, 0);

        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 0, 1, 0);
        send_frame(8'h19, 0, 1, 1);
        chk("full_rw_ovf", overflow, 0);
        for (int i = 0; i < 8; i++) pop_chk();
        chk("full_rw_cnt", ready, 0);

        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO + 20) @(negedge sys_clk);
        chk("to_ferr", err_cnt - e0, 1);
        chk("to_ready", ready, 0);
        send_frame(8'h5A, 0, 1, 0);
        pop_chk();

        send_frame(8'h77, 0, 1, 0);
        chk("pre_rst_ready", ready, 1);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_data", rd_data, 0);
        chk("mid_rst_ovf", overflow, 0);
        q.delete();
        exp_ovf = 1'b0;
        repeat (2) @(negedge sys_clk);
        rst = 1'b1;
        e0 = err_cnt;
        for (int i = 0; i < 7; i++) ps2_bit(1'b1);
        chk("rest_ready", ready, 0);
        chk("rest_ferr", err_cnt - e0, 0);
        send_frame(8'h29, 0, 1, 0);
        pop_chk();
        chk("final_empty", ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
